// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Covers the FSM state encoding, the grant encoding and the word-alignment helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [3:0]  FULL_WORD_BE    = 4'b1111;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Two-way request picker: a lone requester always wins.
// On a tie, prio_data selects the winning side.
module arb_rr_select
    import mem_bus_arbiter_pkg::*;
(
    input  logic   instr_req,
    input  logic   data_req,
    input  logic   prio_data,
    output grant_t grant,
    output logic   grant_valid
);

    // Pick the winner of the current request pair.
    always_comb begin
        grant       = GRANT_I;
        grant_valid = instr_req | data_req;
        if (data_req && (!instr_req || prio_data)) begin
            grant = GRANT_D;
        end else begin
            grant = GRANT_I;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one waitrequest-style memory bus between the CPU fetch and data ports.
// Each access runs IDLE -> IBUS/DBUS -> RESP, and completion is reported with a one-cycle valid pulse.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST  = 1'b1,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_read,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        instr_valid,

    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        data_valid,

    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    state_t      state_r;
    state_t      state_s;
    logic        prio_data_r;
    grant_t      served_r;
    grant_t      grant_s;
    logic        grant_valid_s;
    logic        data_req_s;
    logic        bus_active_s;
    logic        bus_done_s;

    logic [31:0] lat_addr_r;
    logic [31:0] lat_wdata_r;
    logic [3:0]  lat_be_r;
    logic        lat_write_r;

    logic [31:0] instr_readdata_r;
    logic [31:0] data_readdata_r;
    logic        instr_valid_r;
    logic        data_valid_r;

    // A simultaneous read+write from the data port is treated as a store.
    assign data_req_s = data_read | data_write;

    arb_rr_select u_select (
        .instr_req   (instr_read),
        .data_req    (data_req_s),
        .prio_data   (prio_data_r),
        .grant       (grant_s),
        .grant_valid (grant_valid_s)
    );

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_s = (grant_s == GRANT_D) ? DBUS : IBUS;
                end else begin
                    state_s = IDLE;
                end
            end
            IBUS, DBUS: begin
                if (!mem_waitrequest) begin
                    state_s = RESP;
                end else begin
                    state_s = state_r;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Bus outputs come straight from the request latched on entry, so they stay stable while stalled.
    always_comb begin
        bus_active_s   = (state_r == IBUS) || (state_r == DBUS);
        bus_done_s     = bus_active_s && !mem_waitrequest;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = 32'h0000_0000;
        mem_writedata  = 32'h0000_0000;
        mem_byteenable = 4'b0000;
        if (bus_active_s) begin
            mem_read       = !lat_write_r;
            mem_write      = lat_write_r;
            mem_address    = lat_addr_r;
            mem_writedata  = lat_wdata_r;
            mem_byteenable = lat_be_r;
        end else begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    // State register and tie-break priority flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            prio_data_r <= DATA_FIRST;
        end else begin
            state_r <= state_s;
            if (state_r == RESP && ROUND_ROBIN) begin
                prio_data_r <= (served_r == GRANT_I);
            end
        end
    end

    // Capture the winning request in IDLE; later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            served_r    <= GRANT_I;
            lat_addr_r  <= 32'h0000_0000;
            lat_wdata_r <= 32'h0000_0000;
            lat_be_r    <= 4'b0000;
            lat_write_r <= 1'b0;
        end else if (state_r == IDLE && grant_valid_s) begin
            served_r <= grant_s;
            if (grant_s == GRANT_D) begin
                lat_addr_r  <= word_align(data_address);
                lat_wdata_r <= data_writedata;
                lat_be_r    <= data_byteenable;
                lat_write_r <= data_write;
            end else begin
                lat_addr_r  <= word_align(instr_address);
                lat_wdata_r <= 32'h0000_0000;
                lat_be_r    <= FULL_WORD_BE;
                lat_write_r <= 1'b0;
            end
        end
    end

    // Read data capture and completion pulses; the pulse lands in the RESP cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_readdata_r <= 32'h0000_0000;
            data_readdata_r  <= 32'h0000_0000;
            instr_valid_r    <= 1'b0;
            data_valid_r     <= 1'b0;
        end else begin
            instr_valid_r <= 1'b0;
            data_valid_r  <= 1'b0;
            if (bus_done_s) begin
                if (served_r == GRANT_D) begin
                    data_valid_r <= 1'b1;
                    if (!lat_write_r) begin
                        data_readdata_r <= mem_readdata;
                    end
                end else begin
                    instr_valid_r    <= 1'b1;
                    instr_readdata_r <= mem_readdata;
                end
            end
        end
    end

    assign instr_readdata = instr_readdata_r;
    assign data_readdata  = data_readdata_r;
    assign instr_valid    = instr_valid_r;
    assign data_valid     = data_valid_r;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported memory bus (waitrequest handshake) between the CPU instruction-fetch port and data port.
- Lets the Harvard-style core run against a unified memory.
- Sits between the mips_cpu fetch/load-store interfaces and the memory model or bus.
- Sequences each access through a small FSM and returns registered read data with a one-cycle valid pulse.

Parameters:
- DATA_FIRST, 1, side that wins a simultaneous request immediately after reset (1 = data, 0 = instruction).
- ROUND_ROBIN, 1, 1 = alternate priority after every granted access; 0 = fixed priority per DATA_FIRST.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- instr_read  in  1  fetch request; held high until instr_valid.
- instr_address  in  32  byte address of the fetch.
- instr_readdata  out  32  fetched word; valid when instr_valid==1.
- instr_valid  out  1  one-cycle completion pulse for the fetch.
- data_read  in  1  load request; held until data_valid.
- data_write  in  1  store request; held until data_valid.
- data_address  in  32  byte address of the load/store.
- data_writedata  in  32  store data.
- data_byteenable  in  4  store/load byte lanes.
- data_readdata  out  32  load result; valid when data_valid==1.
- data_valid  out  1  one-cycle completion pulse (loads and stores).
- mem_address  out  32  word-aligned bus address, {addr[31:2],2'b00}.
- mem_read  out  1  bus read strobe.
- mem_write  out  1  bus write strobe.
- mem_writedata  out  32  bus write data.
- mem_byteenable  out  4  bus byte lanes; 4'b1111 for fetches.
- mem_waitrequest  in  1  bus stall; transfer completes on a posedge where this is 0.
- mem_readdata  in  32  bus read data, sampled at the completing posedge.

Behaviour:
- FSM states: IDLE, IBUS, DBUS, RESP.
- Reset (reset==0 at posedge): state=IDLE; priority flag=DATA_FIRST; all outputs 0, including readdata registers.
- IDLE: bus strobes 0.
  - Only instr_read high -> IBUS.
  - Only data_read or data_write high -> DBUS.
  - Both high -> the priority side's state.
  - Neither high -> stay in IDLE.
- IBUS/DBUS: strobes, address, writedata and byteenable are driven combinationally from the latched request (captured on entry) and are stable for the whole transfer.
  - While mem_waitrequest==1 at posedge: stay in state, with no limit.
  - At the completing posedge: readdata register <- mem_readdata (reads only), go to RESP, record the granted side.
- RESP: requesting side's valid=1 for exactly this cycle; bus strobes 0; requests are ignored in this cycle so the requester can update them.
  - If ROUND_ROBIN=1, the priority flag becomes the side not just served.
  - Next state is IDLE.
- Minimum latency: request seen in IDLE at cycle 0, bus strobe at cycle 1, valid at cycle 2 with zero wait; each wait cycle adds 1. Throughput is one access per 3 cycles.
- data_read and data_write both high is illegal; the store is performed (mem_write=1, mem_read=0).
- Store completion: data_valid pulses; data_readdata holds its previous value.
- instr_readdata and data_readdata hold their value until the next read of the same side completes.
- Request inputs are sampled only in IDLE (address and data latched then). Changes during IBUS/DBUS have no effect.
- Reset mid-transfer: strobes drop to 0 in the cycle after the reset edge; the transfer is abandoned; no valid is issued.
- mem_read and mem_write are never both 1; IBUS never asserts mem_write.

Decomposition:
- Package mem_bus_arbiter_pkg: state enum (IDLE, IBUS, DBUS, RESP), grant enum (GRANT_I, GRANT_D), word-align mask constant.
- One sub-module, arb_rr_select: combinational 2-way picker taking (instr_req, data_req, prio_data) and producing grant plus a grant-valid flag. Priority-flag update stays in the parent.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-DBUS with waitrequest=1 -> mem_read=mem_write=0 and both valids=0 after the edge; no valid ever appears for the abandoned access.
- Single fetch: instr_read=1, addr=0xBFC00003, waitrequest=0, mem_readdata=0x24020005 -> mem_address=0xBFC00000, mem_byteenable=4'hF, instr_valid high exactly at cycle 2 with instr_readdata=0x24020005.
- Wait states: data_read=1, addr=0x1000, waitrequest=1 for 3 cycles -> mem_read held stable 4 cycles, data_valid at cycle 5, data_readdata=mem_readdata sampled at completion.
- Simultaneous, ROUND_ROBIN=1, DATA_FIRST=1: both requests held continuously -> grant order D,I,D,I; each valid 3 cycles apart.
- Store: data_write=1, addr=0x2004, writedata=0xDEADBEEF, byteenable=4'b0011 -> mem_write=1 with same data and lanes, mem_read=0; data_valid pulses; data_readdata unchanged.
- Illegal read+write together -> write performed, mem_read=0; fixed priority with ROUND_ROBIN=0, DATA_FIRST=0 -> instruction always wins ties.
